// File: rtl/sync_fifo.sv
// Single-clock FIFO with binary wrap-bit pointers, threshold flags and sticky error flags.
// Read port is either registered (FWFT=0) or first-word-fall-through (FWFT=1).
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int AF_TH  = (2**ADDR_W) - 2,
    parameter int AE_TH  = 1,
    parameter bit FWFT   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              r_en,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] AF_LVL  = (ADDR_W+1)'(AF_TH);
    localparam logic [ADDR_W:0] AE_LVL  = (ADDR_W+1)'(AE_TH);

    logic [ADDR_W:0]   r_wptr;
    logic [ADDR_W:0]   r_rptr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_ovf;
    logic              r_udf;

    logic [ADDR_W:0]   w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_wr;
    logic              w_rd;
    logic [DATA_W-1:0] w_head;

    // Status is decoded purely from the registered pointers, so it settles with count.
    assign w_count = r_wptr - r_rptr;
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]) &&
                     (r_wptr[ADDR_W] != r_rptr[ADDR_W]);
    assign w_wr    = w_en & ~w_full;
    assign w_rd    = r_en & ~w_empty;
    assign w_head  = r_mem[r_rptr[ADDR_W-1:0]];

    assign count        = w_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (w_count >= AF_LVL);
    assign almost_empty = (w_count <= AE_LVL);
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

    // Pointer update; each pointer moves only on its own accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    // Storage array; contents are deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (w_wr && !rst) begin
            r_mem[r_wptr[ADDR_W-1:0]] <= data_in;
        end
    end

    // Sticky error flags; a new error in the same cycle wins over clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_en && w_full) begin
                r_ovf <= 1'b1;
            end else if (clr_err) begin
                r_ovf <= 1'b0;
            end
            if (r_en && w_empty) begin
                r_udf <= 1'b1;
            end else if (clr_err) begin
                r_udf <= 1'b0;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign data_out = w_empty ? '0 : w_head;
        end else begin : g_reg
            logic [DATA_W-1:0] r_dout;

            // Registered read data; holds across idle and rejected reads.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dout <= '0;
                end else if (w_rd) begin
                    r_dout <= w_head;
                end
            end

            assign data_out = r_dout;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: one registered-read and one FWFT instance share identical stimulus
// and are compared every cycle against a queue-based model, plus directed literal checks.
module tb_sync_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_en;
    logic [15:0] data_in;
    logic        r_en;
    logic        clr_err;

    logic [15:0] dout0, dout1;
    logic        full0, empty0, af0, ae0, ovf0, udf0;
    logic        full1, empty1, af1, ae1, ovf1, udf1;
    logic [3:0]  cnt0, cnt1;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] q[$];
    logic        m_ovf  = 1'b0;
    logic        m_udf  = 1'b0;
    logic [15:0] m_dout = 16'h0000;

    always #5 clk = ~clk;

    sync_fifo #(.DATA_W(16), .ADDR_W(3), .AF_TH(6), .AE_TH(1), .FWFT(1'b0)) u_reg (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en), .clr_err(clr_err),
        .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(udf0));

    sync_fifo #(.DATA_W(16), .ADDR_W(3), .AF_TH(6), .AE_TH(1), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en), .clr_err(clr_err),
        .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(udf1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model of one clock edge, evaluated from the occupancy before the edge.
    task automatic model_step(input logic w, input logic [15:0] d, input logic r, input logic c);
        int sz;
        sz = q.size();
        if (w && sz == 8) m_ovf = 1'b1;
        else if (c)       m_ovf = 1'b0;
        if (r && sz == 0) m_udf = 1'b1;
        else if (c)       m_udf = 1'b0;
        if (r && sz > 0)  m_dout = q.pop_front();
        if (w && sz < 8)  q.push_back(d);
    endtask

    task automatic cyc(input logic w, input logic [15:0] d, input logic r, input logic c);
        w_en = w; data_in = d; r_en = r; clr_err = c;
        @(posedge clk);
        model_step(w, d, r, c);
        #2;
    endtask

    task automatic do_rst();
        w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
        rst = 1'b1;
        q.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_dout = 16'h0000;
        #1;
        chk("rst_count", 32'(cnt0), 32'd0);
        chk("rst_empty", 32'(empty0), 32'd1);
        chk("rst_ae", 32'(ae0), 32'd1);
        chk("rst_af", 32'(af0), 32'd0);
        chk("rst_full", 32'(full0), 32'd0);
        chk("rst_ovf", 32'(ovf0), 32'd0);
        chk("rst_udf", 32'(udf0), 32'd0);
        chk("rst_dout_reg", 32'(dout0), 32'd0);
        chk("rst_dout_fwft", 32'(dout1), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int sz;
        sz = q.size();
        chk("count_reg", 32'(cnt0), 32'(sz));
        chk("count_fwft", 32'(cnt1), 32'(sz));
        chk("empty_reg", 32'(empty0), 32'(sz == 0));
        chk("empty_fwft", 32'(empty1), 32'(sz == 0));
        chk("full_reg", 32'(full0), 32'(sz == 8));
        chk("full_fwft", 32'(full1), 32'(sz == 8));
        chk("af_reg", 32'(af0), 32'(sz >= 6));
        chk("af_fwft", 32'(af1), 32'(sz >= 6));
        chk("ae_reg", 32'(ae0), 32'(sz <= 1));
        chk("ae_fwft", 32'(ae1), 32'(sz <= 1));
        chk("ovf_reg", 32'(ovf0), 32'(m_ovf));
        chk("ovf_fwft", 32'(ovf1), 32'(m_ovf));
        chk("udf_reg", 32'(udf0), 32'(m_udf));
        chk("udf_fwft", 32'(udf1), 32'(m_udf));
        chk("dout_reg", 32'(dout0), 32'(m_dout));
        chk("dout_fwft", 32'(dout1), (sz > 0) ? 32'(q[0]) : 32'd0);
    end

    initial begin
        rst = 1'b1; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; data_in = 16'h0000;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        chk("init_count", 32'(cnt0), 32'd0);
        chk("init_empty", 32'(empty1), 32'd1);

        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 16'(i), 1'b0, 1'b0);
            chk("fill_count", 32'(cnt0), 32'(i));
            if (i == 5) chk("af_at5", 32'(af0), 32'd0);
            if (i == 6) chk("af_at6", 32'(af0), 32'd1);
            if (i == 7) chk("full_at7", 32'(full0), 32'd0);
        end
        chk("full_at8", 32'(full0), 32'd1);

        cyc(1'b1, 16'h00AA, 1'b0, 1'b0);
        chk("ovf_set", 32'(ovf0), 32'd1);
        chk("ovf_count", 32'(cnt0), 32'd8);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("ovf_clr", 32'(ovf0), 32'd0);

        for (int i = 1; i <= 8; i++) begin
            chk("fwft_head", 32'(dout1), 32'(i));
            cyc(1'b0, 16'h0000, 1'b1, 1'b0);
            chk("drain_dout", 32'(dout0), 32'(i));
        end
        chk("drain_empty", 32'(empty0), 32'd1);
        chk("drain_fwft_zero", 32'(dout1), 32'd0);

        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("udf_set", 32'(udf0), 32'd1);
        chk("udf_hold", 32'(dout0), 32'h0008);
        chk("udf_count", 32'(cnt0), 32'd0);

        for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'h0010 + i), 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            cyc(1'b1, 16'(16'h0014 + k), 1'b1, 1'b0);
            chk("simul_count", 32'(cnt0), 32'd4);
            chk("simul_dout", 32'(dout0), 32'(16'h0010 + k));
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

        cyc(1'b1, 16'h1234, 1'b0, 1'b0);
        chk("fwft_1234", 32'(dout1), 32'h1234);
        chk("fwft_nonempty", 32'(empty1), 32'd0);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("fwft_pop_empty", 32'(empty1), 32'd1);
        chk("fwft_pop_zero", 32'(dout1), 32'd0);

        for (int ph = 0; ph < 3; ph++) begin
            int wp;
            wp = (ph == 0) ? 70 : (ph == 1) ? 30 : 50;
            for (int n = 0; n < 150; n++) begin
                cyc($urandom_range(0, 99) < wp, 16'($urandom),
                    $urandom_range(0, 99) < (100 - wp), $urandom_range(0, 15) == 0);
            end
        end

        for (int k = 0; k < 8; k++) if (q.size() > 0) cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
        chk("pre_rst_count", 32'(cnt0), 32'd5);
        do_rst();
        cyc(1'b1, 16'h0BEE, 1'b0, 1'b0);
        chk("post_rst_count", 32'(cnt0), 32'd1);
        chk("post_rst_fwft", 32'(dout1), 32'h0BEE);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width in bits (>=1).
REQ-002 SHALL have parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W (default 8).
REQ-003 SHALL have parameter AF_TH, default DEPTH-2, almost-full threshold (1..DEPTH).
REQ-004 SHALL have parameter AE_TH, default 1, almost-empty threshold (0..DEPTH-1).
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port w_en  input  1  write request.
REQ-009 SHALL have port data_in  input  DATA_W  write data.
REQ-010 SHALL have port r_en  input  1  read request (pop in FWFT mode).
REQ-011 SHALL have port clr_err  input  1  synchronous clear of sticky error flags.
REQ-012 SHALL have port data_out  output  DATA_W  read data.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have port count  output  ADDR_W+1  number of stored words, 0..DEPTH.
REQ-015 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL keep binary write/read pointers of ADDR_W+1 bits; low ADDR_W bits index storage, MSB is the wrap bit; pointers wrap modulo 2**(ADDR_W+1).
REQ-017 SHALL assert empty when pointers are equal; full when low bits equal and MSBs differ.
REQ-018 SHALL accept a write iff w_en=1 and full=0; accepted write stores data_in at write index and increments write pointer.
REQ-019 SHALL accept a read iff r_en=1 and empty=0; accepted read increments read pointer.
REQ-020 SHALL reject a write when full=1 even if a read is accepted in the same cycle; storage and write pointer unchanged.
REQ-021 SHALL, on simultaneous accepted read and write (0<count<DEPTH), perform both; count unchanged.
REQ-022 SHALL compute count = write pointer - read pointer, modulo 2**(ADDR_W+1); all flags derived from registered pointers, valid same cycle as count.
REQ-023 SHALL drive almost_full = (count >= AF_TH) and almost_empty = (count <= AE_TH).
REQ-024 FWFT=0: data_out SHALL be registered, updated to the head word on the clock edge of an accepted read (one-cycle latency), and SHALL hold its value otherwise, including on rejected reads.
REQ-025 FWFT=1: data_out SHALL combinationally present the head word whenever empty=0 and SHALL be 0 when empty=1; an accepted read advances to the next word on the following cycle.
REQ-026 SHALL set overflow on any cycle with w_en=1 and full=1; set underflow on any cycle with r_en=1 and empty=1; both remain set until clr_err or rst.
REQ-027 SHALL give set priority over clr_err when both occur in the same cycle.

Reset
REQ-028 SHALL, while rst=1 (asynchronously, also mid-operation), force both pointers to 0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, data_out=0.
REQ-029 SHALL ignore w_en, r_en and clr_err while rst=1; storage contents need not be cleared; first edge after rst deasserts SHALL operate normally.

Verification (DATA_W=16, ADDR_W=3, AF_TH=6, AE_TH=1)
REQ-030 Reset: assert rst mid-burst with count=5 -> count=0, empty=1, almost_empty=1, flags 0, data_out=0 immediately, without a clock edge.
REQ-031 Fill/drain FWFT=0: write 0x0001..0x0008 -> almost_full at count 6, full at 8; then 8 reads -> data_out 0x0001..0x0008 one cycle after each read, empty=1 at end.
REQ-032 Overflow: at full write 0x00AA -> overflow=1, count stays 8, 0x00AA never read out; clr_err -> overflow=0.
REQ-033 Underflow: read on empty FWFT=0 -> underflow=1, data_out holds last value, count stays 0.
REQ-034 Simultaneous: count=4, w_en=r_en=1 for 12 cycles -> count stays 4, output sequence in-order across pointer wrap.
REQ-035 FWFT=1: write 0x1234 into empty FIFO -> data_out=0x1234 the cycle after the write with empty=0; pop -> empty=1, data_out=0.
